// File: rtl/fetch_dec_buf_if.sv
// Fetch-to-decode handshake bundle: ready/valid in and out, flush, and occupancy.
// FETCH_DEC_BUF_STATS_EN adds the stall_cycles / flush_drops statistics signals.
interface fetch_dec_buf_if #(
    parameter int DATA_W = 96
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        count;
`ifdef FETCH_DEC_BUF_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_drops;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count, stall_cycles, flush_drops
    );
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count, stall_cycles, flush_drops
    );
`else
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );
`endif
endinterface

// File: rtl/fetch_dec_buf.sv
// Two-entry elastic buffer between fetch and decode with redirect flush.
// Optional statistics counters are enabled by FETCH_DEC_BUF_STATS_EN.
module fetch_dec_buf #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset,
    fetch_dec_buf_if.slave  bus
);
    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic              wp_r;
    logic              rp_r;
    logic [1:0]        count_r;
    logic              push_s;
    logic              pop_s;

    // in_ready only looks at registered occupancy, so out_ready never reaches it
    assign bus.in_ready  = (count_r != 2'd2);
    assign bus.out_valid = (count_r != 2'd0);
    assign bus.out_data  = mem_r[rp_r];
    assign bus.count     = count_r;

    assign push_s = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop_s  = bus.out_valid && bus.out_ready && !bus.flush;

    // Storage, pointers and occupancy; flush rewinds pointers but keeps stale data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wp_r    <= 1'b0;
            rp_r    <= 1'b0;
            count_r <= 2'd0;
        end else if (bus.flush) begin
            wp_r    <= 1'b0;
            rp_r    <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wp_r] <= bus.in_data;
                wp_r        <= ~wp_r;
            end
            if (pop_s) begin
                rp_r <= ~rp_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

`ifdef FETCH_DEC_BUF_STATS_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_drops_r;
    logic [2:0]  drop_amt_s;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {30'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // A flush discards the buffered entries plus any record handshaken in that cycle
    assign drop_amt_s = {1'b0, count_r} + {2'd0, (bus.in_valid && bus.in_ready)};

    // Saturating statistics; flush does not clear them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= 32'd0;
            flush_drops_r  <= 32'd0;
        end else begin
            if (bus.in_valid && !bus.in_ready && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (bus.flush) begin
                flush_drops_r <= sat_add(flush_drops_r, drop_amt_s);
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_drops  = flush_drops_r;
`endif
endmodule

// File: tb/tb_fetch_dec_buf.sv
// Randomized and directed bench for fetch_dec_buf against a queue-based reference model.
module tb_fetch_dec_buf;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    bit   cmp_en;

    fetch_dec_buf_if #(.DATA_W(96)) bus ();

    fetch_dec_buf #(.DATA_W(96), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bounded queue plus plain counters
    logic [95:0] mq[$];
    longint      m_stall;
    longint      m_drops;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_stall = 0;
            m_drops = 0;
        end else begin
            bit full;
            bit acc;
            full = (mq.size() == 2);
            acc  = bus.in_valid && !full;
            if (bus.in_valid && full && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (bus.flush) begin
                m_drops += mq.size() + (acc ? 1 : 0);
                if (m_drops > 64'hFFFF_FFFF) m_drops = 64'hFFFF_FFFF;
                mq.delete();
            end else begin
                if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
                if (acc) mq.push_back(bus.in_data);
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count_le_2", {127'd0, (bus.count <= 2'd2)}, 128'd1);
            chk("count", {126'd0, bus.count}, 128'(mq.size()));
            chk("out_valid", {127'd0, bus.out_valid}, {127'd0, (mq.size() != 0)});
            chk("in_ready", {127'd0, bus.in_ready}, {127'd0, (mq.size() != 2)});
            if (mq.size() != 0) chk("out_data", {32'd0, bus.out_data}, {32'd0, mq[0]});
`ifdef FETCH_DEC_BUF_STATS_EN
            chk("stall_cycles", {96'd0, bus.stall_cycles}, 128'(m_stall));
            chk("flush_drops", {96'd0, bus.flush_drops}, 128'(m_drops));
`endif
        end
    end

    task automatic drv(input bit v, input logic [95:0] d, input bit ordy, input bit fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cmp_en    = 1'b0;
        drv(1'b0, 96'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("rst_count", {126'd0, bus.count}, 128'd0);
        chk("rst_out_data", {32'd0, bus.out_data}, 128'd0);
        @(negedge clk);
        reset  = 1'b1;
        cmp_en = 1'b1;

        // Single push with 1-cycle latency
        drv(1'b1, 96'h0000_0000_8000_0000_0000_0013, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("t1_data", {32'd0, bus.out_data}, {32'd0, 96'h0000_0000_8000_0000_0000_0013});
        chk("t1_count", {126'd0, bus.count}, 128'd1);
        drv(1'b0, 96'd0, 1'b1, 1'b0);
        @(negedge clk);

        // Fill and stall
        drv(1'b1, 96'd1, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 96'd2, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 96'd3, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("fill_count", {126'd0, bus.count}, 128'd2);
        chk("fill_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("fill_head", {32'd0, bus.out_data}, 128'd1);

        // Drain in order
        drv(1'b0, 96'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("drain_2", {32'd0, bus.out_data}, 128'd2);
        @(negedge clk);
        chk("drain_empty", {127'd0, bus.out_valid}, 128'd0);
        chk("drain_count", {126'd0, bus.count}, 128'd0);

        // Streaming with simultaneous push/pop at count=1
        for (int i = 10; i < 14; i++) begin
            drv(1'b1, 96'(i), 1'b1, 1'b0);
            @(negedge clk);
            chk("stream_data", {32'd0, bus.out_data}, 128'(i));
            chk("stream_count", {126'd0, bus.count}, 128'd1);
        end
        drv(1'b0, 96'd0, 1'b1, 1'b0);
        @(negedge clk);

        // Flush with a full buffer and a pending record
        drv(1'b1, 96'd5, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 96'd6, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 96'd7, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_count", {126'd0, bus.count}, 128'd0);
        chk("flush_valid", {127'd0, bus.out_valid}, 128'd0);
`ifdef FETCH_DEC_BUF_STATS_EN
        chk("flush_drops_lit", {96'd0, bus.flush_drops}, 128'd2);
        chk("stall_lit", {96'd0, bus.stall_cycles}, 128'd3);
`endif
        drv(1'b1, 96'd8, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_flush_data", {32'd0, bus.out_data}, 128'd8);
        chk("post_flush_count", {126'd0, bus.count}, 128'd1);
        drv(1'b0, 96'd0, 1'b1, 1'b0);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom},
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            @(negedge clk);
        end

        // Asynchronous reset mid-stream with a full buffer
        drv(1'b1, 96'hA1, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 96'hA2, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", {126'd0, bus.count}, 128'd2);
        cmp_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("async_count", {126'd0, bus.count}, 128'd0);
        chk("async_in_ready", {127'd0, bus.in_ready}, 128'd1);
`ifdef FETCH_DEC_BUF_STATS_EN
        chk("async_stall", {96'd0, bus.stall_cycles}, 128'd0);
`endif
        drv(1'b0, 96'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_dec_buf.md
Name: fetch_dec_buf

Overview:
- Receiving end of the fetch→decode interface: a 2-entry ready/valid elastic buffer.
- Takes fetch_data_t records (PC plus instruction) from the fetch stage and presents them in order to decode.
- Lets fetch keep running for one cycle after decode stalls.
- Supports a redirect flush that discards everything buffered.
- in_ready depends only on internal state. There is no combinational path from out_ready to in_ready.

Parameters:
- DATA_W, 96, width of the packed fetch_data_t (64-bit PC + 32-bit instruction); must equal $bits(fetch_data_t).
- DEPTH, 2, number of entries; fixed at 2, and other values are not supported.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block immediately.
- in_valid  in  1  fetch presents a valid record.
- in_ready  out  1  buffer can accept a record this cycle.
- in_data  in  DATA_W  fetch_data_t record from fetch.
- out_valid  out  1  record available to decode.
- out_ready  in  1  decode consumes the record this cycle.
- out_data  out  DATA_W  oldest buffered record.
- flush  in  1  synchronous discard of all entries (branch redirect / exception).
- count  out  2  occupancy, 0..2.

Behaviour:
- State: entry storage mem[0:1], 1-bit write pointer wp, 1-bit read pointer rp, 2-bit count.
- Reset (reset=0, asynchronous):
  - wp=0, rp=0, count=0, mem[*]=0.
  - Outputs during and after reset: out_valid=0, in_ready=1, out_data=0, count=0.
  - Reset asserted mid-transfer drops all entries. A handshake in that cycle is lost.
- in_ready = (count != 2). It is a function of registered count only.
- out_valid = (count != 0). out_data = mem[rp], driven combinationally from registers.
- push = in_valid && in_ready && !flush. pop = out_valid && out_ready && !flush.
- On the clock edge:
  - push: mem[wp] <= in_data; wp <= ~wp.
  - pop: rp <= ~rp.
  - count <= count + push − pop.
- Latency: a record pushed at edge N is visible on out_data/out_valid after edge N. This is 1 cycle, with no bypass from in_data to out_data.
- Simultaneous push and pop:
  - count=1: count stays 1, pointers both toggle.
  - count=2: push is impossible (in_ready=0), so only the pop happens and count becomes 1.
  - count=0: pop is impossible, so only the push happens.
- Full (count=2): in_ready=0; in_data is ignored and fetch must hold it. Empty (count=0): out_valid=0; out_data holds the stale mem[rp] value, and decode must not sample it.
- flush=1 at an edge:
  - wp <= 0, rp <= 0, count <= 0. mem contents are unchanged.
  - Flush overrides any push or pop in that cycle; the incoming record is dropped.
  - in_ready stays as computed from current count during the flush cycle. Fetch treats flush as a redirect and discards its own handshake.
- Record order is strict FIFO. Pointers wrap 1→0 naturally.
- count never exceeds 2 and never underflows. The bench asserts this.

Optional Feature:
- Macro: FETCH_DEC_BUF_STATS_EN.
- Defined:
  - Adds output port stall_cycles (32 bits). It increments each cycle in which in_valid=1 and in_ready=0, saturating at 0xFFFF_FFFF.
  - Adds output port flush_drops (32 bits), which adds count + (in_valid && in_ready) on each flush edge. Only the counter saturates; the occupancy count is unaffected.
  - Both counters reset to 0 on reset=0 and are not cleared by flush.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset and single push: hold reset=0 for 3 cycles, then release. Check out_valid=0, in_ready=1, count=0. Push in_data=0x…8000_0000_0000_0013 → after 1 edge, out_valid=1, out_data equals that value, count=1.
- Fill and stall: out_ready=0, push A=1, B=2 on consecutive edges → count=2, in_ready=0. Hold C=3 for 2 cycles → not accepted, count stays 2, out_data=1.
- Drain in order: after the fill, set out_ready=1 and in_valid=0 → out_data sequence 1, 2, then out_valid=0, count=0.
- Simultaneous push/pop at count=1: streaming 10, 11, 12, 13 with out_ready=1 every cycle → output sequence 10, 11, 12, 13 with 1-cycle latency, count stays 1 during steady state.
- Flush: count=2 (entries 5, 6), assert flush with in_valid=1, in_data=7 → next cycle count=0, out_valid=0. Next push of 8 appears as out_data=8, and 5, 6, 7 are never output.
- Async reset mid-stream: count=2, drop reset between clock edges → out_valid=0 and count=0 immediately, before any clock edge. With FETCH_DEC_BUF_STATS_EN, stall_cycles=0.
